// File: rtl/reg_cmd_sequencer_4b_pkg.sv
// Shared types for the 4-bit register command sequencer: opcodes, FSM
// states, strobe bundle and the carry-source select.
package reg_cmd_sequencer_4b_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_CLEAR = 3'b001,
    OP_INC   = 3'b010,
    OP_DEC   = 3'b011,
    OP_SHR   = 3'b100,
    OP_SHL   = 3'b101,
    OP_ROR   = 3'b110,
    OP_ROL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Source of the register carry input while executing.
  typedef enum logic [1:0] {
    CSEL_ZERO    = 2'b00,
    CSEL_LATCHED = 2'b01,
    CSEL_LIVE    = 2'b10
  } csel_e;

  typedef struct packed {
    logic ld;
    logic clr;
    logic inc;
    logic dec;
    logic shr;
    logic shl;
  } strobe_t;

  // Latched command; the repeat count goes straight into the step counter.
  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] data;
    logic              carry;
  } cmd_t;

  // LOAD and CLEAR are single-step; everything else honours the repeat count.
  function automatic logic is_multi_step(input op_e op);
    return !(op == OP_LOAD || op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/reg_cmd_sequencer_4b_if.sv
// Command handshake plus the strobe/data bus towards the downstream register.
interface reg_cmd_sequencer_4b_if;
  import reg_cmd_sequencer_4b_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_carry;
  logic              abort;
  logic              reg_carry;
  logic              ld;
  logic              clr;
  logic              inc;
  logic              dec;
  logic              shr;
  logic              shl;
  logic [DATA_W-1:0] data_out;
  logic              input_carry;
  logic              busy;
  logic              done;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_carry, abort, reg_carry,
    output cmd_ready, ld, clr, inc, dec, shr, shl, data_out, input_carry, busy, done
  );

  // Command issuer / register model side.
  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_carry, abort, reg_carry,
    input  cmd_ready, ld, clr, inc, dec, shr, shl, data_out, input_carry, busy, done
  );

endinterface

// File: rtl/reg_cmd_sequencer_4b_decode.sv
// Pure decode of (state, latched op) into one strobe and a carry source.
// Nothing from the live command bus reaches here, so strobes are Moore outputs.
module reg_cmd_decode
  import reg_cmd_sequencer_4b_pkg::*;
(
  input  state_e  state,
  input  op_e     op,
  output strobe_t strb,
  output csel_e   csel
);

  // One strobe per EXEC cycle; rotates reuse the shift strobes with a live carry.
  always_comb begin
    strb = '0;
    csel = CSEL_ZERO;
    if (state == ST_EXEC) begin
      case (op)
        OP_LOAD:  strb.ld  = 1'b1;
        OP_CLEAR: strb.clr = 1'b1;
        OP_INC:   strb.inc = 1'b1;
        OP_DEC:   strb.dec = 1'b1;
        OP_SHR:   begin strb.shr = 1'b1; csel = CSEL_LATCHED; end
        OP_SHL:   begin strb.shl = 1'b1; csel = CSEL_LATCHED; end
        OP_ROR:   begin strb.shr = 1'b1; csel = CSEL_LIVE;    end
        OP_ROL:   begin strb.shl = 1'b1; csel = CSEL_LIVE;    end
        default:  strb = '0;
      endcase
    end
  end

endmodule

// File: rtl/reg_cmd_sequencer_4b.sv
// Accepts one command at a time and replays it as 1..4 strobe cycles to a
// downstream 4-bit register, then pulses done for a cycle before re-arming.
module reg_cmd_sequencer_4b
  import reg_cmd_sequencer_4b_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  reg_cmd_sequencer_4b_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q;
  logic             accept;
  strobe_t          strb;
  csel_e            csel;

  // Ready only while idle and out of reset; rst gates it combinationally.
  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Next-state and step counter; the counter parks at 0 whenever EXEC ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          cnt_d   = is_multi_step(op_e'(bus.cmd_op)) ? bus.cmd_count : '0;
        end
      end
      ST_EXEC: begin
        if (bus.abort || cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and command latch; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cmd_q.op    <= op_e'(bus.cmd_op);
        cmd_q.data  <= bus.cmd_data;
        cmd_q.carry <= bus.cmd_carry;
      end
    end
  end

  reg_cmd_decode u_decode (
    .state (state_q),
    .op    (cmd_q.op),
    .strb  (strb),
    .csel  (csel)
  );

  // Carry into the register: latched fill for shifts, live feedback for rotates.
  always_comb begin
    case (csel)
      CSEL_LATCHED: bus.input_carry = cmd_q.carry;
      CSEL_LIVE:    bus.input_carry = bus.reg_carry;
      default:      bus.input_carry = 1'b0;
    endcase
  end

  assign bus.ld       = strb.ld;
  assign bus.clr      = strb.clr;
  assign bus.inc      = strb.inc;
  assign bus.dec      = strb.dec;
  assign bus.shr      = strb.shr;
  assign bus.shl      = strb.shl;
  assign bus.data_out = cmd_q.data;
  assign bus.busy     = (state_q == ST_EXEC);
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_cmd_sequencer_4b.sv
// Directed bench: a vector table of full commands plus hand sequences for
// abort, held cmd_valid while busy, and mid-command reset.
module tb_reg_cmd_sequencer_4b;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  reg_cmd_sequencer_4b_if bus ();

  reg_cmd_sequencer_4b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {op, count, data, fill, reg_carry per step, expected strobe {ld,clr,inc,dec,shr,shl}, steps, carry per step}
  typedef struct {
    logic [2:0] op;
    logic [1:0] cnt;
    logic [3:0] data;
    logic       cfill;
    logic [3:0] rc;
    logic [5:0] strb;
    int         n;
    logic [3:0] ic;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [5:0] strobes();
    return {bus.ld, bus.clr, bus.inc, bus.dec, bus.shr, bus.shl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bounded wait for cmd_ready, sampled mid-cycle.
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    bus.cmd_op    = v.op;
    bus.cmd_count = v.cnt;
    bus.cmd_data  = v.data;
    bus.cmd_carry = v.cfill;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    // scramble the bus to prove the command was latched
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~v.op;
    bus.cmd_count = ~v.cnt;
    bus.cmd_data  = ~v.data;
    bus.cmd_carry = ~v.cfill;
    for (int k = 0; k < v.n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      bus.reg_carry = v.rc[k];
      @(negedge clk);
      chk({nm, "_strb"}, {26'd0, strobes()}, {26'd0, v.strb});
      chk({nm, "_ic"},   {31'd0, bus.input_carry}, {31'd0, v.ic[k]});
      chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({nm, "_data"}, {28'd0, bus.data_out}, {28'd0, v.data});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({nm, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({nm, "_dstrb"}, {26'd0, strobes()}, 32'd0);
    chk({nm, "_dic"}, {31'd0, bus.input_carry}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    chk({nm, "_idone"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int ndec, nclr;
    vecs[0] = '{3'b000, 2'd3, 4'hA, 1'b1, 4'b1111, 6'b100000, 1, 4'b0000}; // LOAD, count ignored
    vecs[1] = '{3'b001, 2'd2, 4'h3, 1'b1, 4'b1111, 6'b010000, 1, 4'b0000}; // CLEAR
    vecs[2] = '{3'b010, 2'd0, 4'h1, 1'b1, 4'b1111, 6'b001000, 1, 4'b0000}; // INC x1
    vecs[3] = '{3'b011, 2'd1, 4'h5, 1'b0, 4'b1111, 6'b000100, 2, 4'b0000}; // DEC x2
    vecs[4] = '{3'b100, 2'd1, 4'h6, 1'b0, 4'b1111, 6'b000010, 2, 4'b0000}; // SHR fill 0
    vecs[5] = '{3'b101, 2'd2, 4'h7, 1'b1, 4'b0000, 6'b000001, 3, 4'b0111}; // SHL fill 1 x3
    vecs[6] = '{3'b110, 2'd3, 4'h8, 1'b0, 4'b0101, 6'b000010, 4, 4'b0101}; // ROR rc 1,0,1,0
    vecs[7] = '{3'b111, 2'd1, 4'h9, 1'b1, 4'b0010, 6'b000001, 2, 4'b0010}; // ROL rc 0,1
    vecs[8] = '{3'b100, 2'd3, 4'hC, 1'b1, 4'b0000, 6'b000010, 4, 4'b1111}; // SHR fill 1 x4

    rst = 1'b1;
    bus.cmd_valid = 1'b1;  // must be overridden by reset
    bus.cmd_op    = 3'b000;
    bus.cmd_count = 2'd0;
    bus.cmd_data  = 4'hF;
    bus.cmd_carry = 1'b1;
    bus.abort     = 1'b0;
    bus.reg_carry = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_strb",  {26'd0, strobes()}, 32'd0);
    chk("rst_busy",  {30'd0, bus.busy, bus.done}, 32'd0);
    chk("rst_data",  {28'd0, bus.data_out}, 32'd0);
    chk("rst_ic",    {31'd0, bus.input_carry}, 32'd0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("idle_abort_busy", {30'd0, bus.busy, bus.done}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // INC x4 aborted in the 2nd strobe cycle
    bus.cmd_op = 3'b010; bus.cmd_count = 2'd3; bus.cmd_data = 4'h2; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_c1_inc", {31'd0, bus.inc}, 32'd1);
    @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_c2_inc", {31'd0, bus.inc}, 32'd1);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_c3_inc", {31'd0, bus.inc}, 32'd0);
    chk("abort_c3_done", {31'd0, bus.done}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // cmd_valid held with CLEAR during a DEC x2: not queued, one clr later
    bus.cmd_op = 3'b011; bus.cmd_count = 2'd1; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_op = 3'b001;
    ndec = 0;
    nclr = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
        if (i == 5) bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      ndec += int'(bus.dec);
      nclr += int'(bus.clr);
      if (i == 3) chk("hold_clr_early", {31'd0, bus.clr}, 32'd0);
      if (i == 4) chk("hold_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
      if (i == 5) chk("hold_clr_pulse", {31'd0, bus.clr}, 32'd1);
    end
    chk("hold_ndec", ndec, 32'd2);
    chk("hold_nclr", nclr, 32'd1);
    wait_ready();

    // reset in the 2nd cycle of DEC x4
    bus.cmd_op = 3'b011; bus.cmd_count = 2'd3; bus.cmd_data = 4'hB; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst37_c1_dec", {31'd0, bus.dec}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cmd_valid = 1'b1;  // active command and abort must lose to reset
    bus.cmd_op = 3'b000;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("rst37_c2_dec", {31'd0, bus.dec}, 32'd1);
    chk("rst37_c2_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst37_strb", {26'd0, strobes()}, 32'd0);
    chk("rst37_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst37_busy", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("rst37_data", {28'd0, bus.data_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("rst37_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst37_idle_strb", {26'd0, strobes()}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_cmd_sequencer_4b.md
REG_CMD_SEQUENCER_4B -- requirements
Module: reg_cmd_sequencer_4b

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: cmd_valid  input  1  command request.
REQ-004 SHALL have port: cmd_ready  output  1  sequencer can accept a command.
REQ-005 SHALL have port: cmd_op  input  3  opcode: 000 LOAD, 001 CLEAR, 010 INC, 011 DEC, 100 SHR, 101 SHL, 110 ROR, 111 ROL.
REQ-006 SHALL have port: cmd_count  input  2  repeat count minus one (1..4 steps).
REQ-007 SHALL have port: cmd_data  input  4  load value.
REQ-008 SHALL have port: cmd_carry  input  1  serial fill bit for SHR/SHL.
REQ-009 SHALL have port: abort  input  1  terminate current command.
REQ-010 SHALL have port: reg_carry  input  1  carry-out fed back from the downstream 4-bit register.
REQ-011 SHALL have ports: ld, clr, inc, dec, shr, shl  output  1 each  strobes to the downstream register.
REQ-012 SHALL have port: data_out  output  4  drives the register data input.
REQ-013 SHALL have port: input_carry  output  1  drives the register carry input.
REQ-014 SHALL have ports: busy  output  1  command executing; done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE; IDLE->EXEC on cmd_valid&&cmd_ready; EXEC->DONE after last step or on abort; DONE->IDLE unconditionally.
REQ-016 SHALL drive cmd_ready=1 only in IDLE with rst low; busy=1 only in EXEC; done=1 only in DONE.
REQ-017 SHALL latch cmd_op, cmd_count, cmd_data, cmd_carry on the accepting edge; inputs changing afterwards have no effect.
REQ-018 SHALL execute LOAD and CLEAR as exactly one step, ignoring cmd_count.
REQ-019 SHALL execute INC, DEC, SHR, SHL, ROR, ROL as cmd_count+1 consecutive steps, using a 2-bit down-counter loaded with cmd_count.
REQ-020 SHALL assert exactly one strobe per EXEC cycle (LOAD->ld, CLEAR->clr, INC->inc, DEC->dec, SHR/ROR->shr, SHL/ROL->shl); all strobes 0 outside EXEC.
REQ-021 SHALL decode strobes only from registered state and latched opcode (Moore outputs, no combinational path from cmd_* to strobes).
REQ-022 SHALL drive data_out = latched cmd_data at all times (0 after reset).
REQ-023 SHALL drive input_carry = latched cmd_carry for SHR/SHL, = reg_carry (live) for ROR/ROL, 0 for all other ops and outside EXEC.
REQ-024 Latency: command accepted at edge T -> strobes in cycles T+1..T+N (N steps) -> done in cycle T+N+1 -> cmd_ready in cycle T+N+2.
REQ-025 abort high in EXEC SHALL make the current cycle the last strobe cycle, transitioning to DONE at the next edge; abort in IDLE or DONE SHALL be ignored.
REQ-026 cmd_valid while cmd_ready=0 SHALL be ignored, not queued.
REQ-027 Counter SHALL stop at 0 when leaving EXEC; no wrap-around to 3.

Reset
REQ-028 rst high at a rising edge SHALL force IDLE, counter 0, latched op/data/carry 0, overriding any other input including an active command or abort.
REQ-029 After reset, all strobes, input_carry, busy, done SHALL be 0 and data_out 4'h0; cmd_ready SHALL be 0 while rst is high.

Structure
REQ-030 Opcode encodings, FSM state encodings and the data-width constant (4) SHALL live in a shared package/header.
REQ-031 SHALL instantiate one combinational sub-module, reg_cmd_decode, mapping (state, latched op) to the six strobes and the input_carry select.

Verification
REQ-032 Reset, then LOAD with cmd_data=4'hA -> ld=1 for exactly one cycle with data_out=4'hA; done next cycle; cmd_ready one cycle later.
REQ-033 SHL with cmd_count=2, cmd_carry=1 -> shl=1 for 3 consecutive cycles, input_carry=1 throughout, done in the 4th cycle.
REQ-034 ROR with cmd_count=3 while reg_carry toggles 1,0,1,0 -> shr=1 for 4 cycles with input_carry = 1,0,1,0 in the same cycles.
REQ-035 INC with cmd_count=3, abort pulsed in 2nd strobe cycle -> inc=1 for exactly 2 cycles, done in 3rd cycle.
REQ-036 cmd_valid held high with CLEAR during a DEC command -> not accepted until cmd_ready returns; exactly one clr pulse follows.
REQ-037 rst asserted in 2nd cycle of DEC with cmd_count=3 -> all strobes 0 after that edge, cmd_ready=0 while rst high, cmd_ready=1 the cycle after rst falls.
